// File: rtl/mcmem_ctrl.sv
// rtl/mcmem_ctrl.sv - load/store sequencer for a word-wide registered synchronous data memory
// Optional alignment trap: define MCMEM_CTRL_ALIGN_TRAP_EN to turn misaligned/illegal accesses into ERR.
module mcmem_ctrl #(
  parameter int MEM_LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_clrn,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_misalign,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_datain,
  output logic        o_m_we,
  input  logic [31:0] i_m_dataout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [2:0] LC_LAST = 3'(MEM_LAT);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_cnt;
  logic        r_wr;
  logic        r_sext;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic [31:0] r_rdata;

  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic        w_bad;
  logic        w_read_end;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

`ifdef MCMEM_CTRL_ALIGN_TRAP_EN
  always_comb begin
    w_size = i_size;
    w_addr = i_addr;
    w_bad  = (i_size == 2'b11) ||
             ((i_size == 2'b01) && i_addr[0]) ||
             ((i_size == 2'b10) && (i_addr[1:0] != 2'b00));
  end
`else
  // Without the trap the request is normalised: size 11 becomes word, stray low bits are cleared.
  always_comb begin
    w_size = (i_size == 2'b11) ? 2'b10 : i_size;
    w_addr = i_addr;
    if (w_size == 2'b10) begin
      w_addr[1:0] = 2'b00;
    end else if (w_size == 2'b01) begin
      w_addr[0] = 1'b0;
    end
    w_bad = 1'b0;
  end
`endif

  assign w_read_end = (r_state == S_READ) && (r_cnt == LC_LAST);

  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          if (w_bad) begin
            w_next = S_ERR;
          end else if (i_wr && (w_size == 2'b10)) begin
            w_next = S_WRITE;
          end else begin
            w_next = S_READ;
          end
        end
      end
      S_READ: begin
        if (r_cnt == LC_LAST) begin
          w_next = r_wr ? S_WRITE : S_DONE;
        end
      end
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_byte = i_m_dataout[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = i_m_dataout[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    case (r_size)
      2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
      default: w_load = i_m_dataout;
    endcase
  end

  // Write word: store data inserted into the buffered read word, or the whole store word.
  always_comb begin
    w_merge = r_buf;
    case (r_size)
      2'b00:   w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      2'b01:   w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_merge = r_wdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_cnt   <= 3'd0;
      r_wr    <= 1'b0;
      r_sext  <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_buf   <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= 3'd0;
          if (i_req) begin
            r_wr    <= i_wr;
            r_sext  <= i_sext;
            r_size  <= w_size;
            r_addr  <= w_addr;
            r_wdata <= i_wdata;
          end
        end
        S_READ: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_read_end) begin
            r_cnt <= 3'd0;
            r_buf <= i_m_dataout;
            if (!r_wr) begin
              r_rdata <= w_load;
            end
          end
        end
        default: r_cnt <= 3'd0;
      endcase
    end
  end

  assign o_ack      = (r_state == S_DONE) || (r_state == S_ERR);
`ifdef MCMEM_CTRL_ALIGN_TRAP_EN
  assign o_misalign = (r_state == S_ERR);
`else
  assign o_misalign = 1'b0;
`endif
  assign o_m_we     = (r_state == S_WRITE);
  assign o_m_addr   = r_addr;
  assign o_m_datain = w_merge;
  assign o_rdata    = r_rdata;

endmodule

// File: tb/tb_mcmem_ctrl.sv
// tb/tb_mcmem_ctrl.sv - scoreboard bench for mcmem_ctrl against a word-array reference model
module tb_mcmem_ctrl;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sext = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        o_ack, o_misalign, o_m_we;
  logic [31:0] o_rdata, o_m_addr, o_m_datain;
  logic [31:0] m_dataout = 32'd0;

  always #5 clk = ~clk;

  mcmem_ctrl #(.MEM_LAT(LAT)) dut (
    .i_clk(clk), .i_clrn(clrn), .i_req(req), .i_wr(wr), .i_size(size), .i_sext(sext),
    .i_addr(addr), .i_wdata(wdata), .o_ack(o_ack), .o_rdata(o_rdata), .o_misalign(o_misalign),
    .o_m_addr(o_m_addr), .o_m_datain(o_m_datain), .o_m_we(o_m_we), .i_m_dataout(m_dataout)
  );

  // Registered SRAM: address/data/we registered, output registered -> two-edge read latency.
  logic [31:0] sram [0:63];
  logic [5:0]  a_q = 6'd0;
  logic        we_q = 1'b0;
  logic [31:0] d_q = 32'd0;
  always @(posedge clk) begin
    a_q  <= o_m_addr[7:2];
    we_q <= o_m_we;
    d_q  <= o_m_datain;
    if (we_q) sram[a_q] <= d_q;
    m_dataout <= sram[a_q];
  end

  typedef struct {
    int          ack_cyc;
    int          we_cyc;
    int          exp_we;
    logic [31:0] mis;
    logic [31:0] rdata;
    logic [31:0] datain;
    logic [5:0]  idx;
  } exp_t;

  logic [31:0] ref_mem [0:63];
  logic [31:0] ref_rdata = 32'd0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   we_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (clrn) begin
      if (o_m_we) begin
        if (sb.size() == 0) begin
          chk("we_without_txn", 32'd1, 32'd0);
        end else begin
          chk("we_cycle", 32'(cyc), 32'(sb[0].we_cyc));
          chk("we_addr", 32'(o_m_addr[7:2]), 32'(sb[0].idx));
          chk("we_data", o_m_datain, sb[0].datain);
          we_seen++;
        end
      end
      if (o_ack) begin
        if (sb.size() == 0) begin
          chk("ack_without_txn", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
          chk("misalign", 32'(o_misalign), mon_e.mis);
          chk("rdata", o_rdata, mon_e.rdata);
          chk("we_count", 32'(we_seen), 32'(mon_e.exp_we));
          we_seen = 0;
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                       input logic [31:0] wd, input bit immediate, input bit commit);
    exp_t        e;
    logic [31:0] na, word, v, mask, nw;
    logic [1:0]  nsz;
    logic        bad;
    int          sh, c0;
    if (!immediate) @(negedge clk);
    wr = w; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
    c0  = immediate ? cyc + 1 : cyc;
    nsz = sz;
    na  = a;
    bad = 1'b0;
`ifdef MCMEM_CTRL_ALIGN_TRAP_EN
    bad = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
`else
    if (nsz == 2'd3) nsz = 2'd2;
    if (nsz == 2'd2) na = a - (a % 4);
    else if (nsz == 2'd1) na = a - (a % 2);
`endif
    e.idx    = na[7:2];
    e.mis    = 32'(bad);
    e.exp_we = 0;
    e.we_cyc = -1;
    e.datain = 32'd0;
    word     = ref_mem[e.idx];
    sh       = (nsz == 2'd0) ? 8 * int'(na % 4) : 16 * int'((na / 2) % 2);
    mask     = (nsz == 2'd0) ? 32'hFF : 32'hFFFF;
    if (bad) begin
      e.ack_cyc = c0 + 1;
    end else if (!w) begin
      if (nsz == 2'd2) begin
        v = word;
      end else begin
        v = (word >> sh) & mask;
        if (sx && v > (mask >> 1)) v = v | ~mask;
      end
      ref_rdata = v;
      e.ack_cyc = c0 + LAT + 2;
    end else begin
      if (nsz == 2'd2) begin
        nw = wd;
        e.we_cyc  = c0 + 1;
        e.ack_cyc = c0 + 2;
      end else begin
        nw = (word & ~(mask << sh)) | ((wd & mask) << sh);
        e.we_cyc  = c0 + LAT + 2;
        e.ack_cyc = c0 + LAT + 3;
      end
      e.exp_we = 1;
      e.datain = nw;
      if (commit) ref_mem[e.idx] = nw;
    end
    e.rdata = ref_rdata;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input bit hold);
    bit got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = o_ack;
    end
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    if (!hold || !got) req = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"}, 32'(o_ack), 32'd0);
    chk({tag, "_misalign"}, 32'(o_misalign), 32'd0);
    chk({tag, "_m_we"}, 32'(o_m_we), 32'd0);
    chk({tag, "_rdata"}, o_rdata, 32'd0);
    chk({tag, "_m_addr"}, o_m_addr, 32'd0);
    chk({tag, "_m_datain"}, o_m_datain, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv;
    bit          h, h_prev;
    for (int i = 0; i < 64; i++) begin
      rv = $urandom;
      if (i == 4) rv = 32'h8899AABB;
      sram[i] <= rv;
      ref_mem[i] = rv;
    end
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    clrn = 1'b1;

    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1); wait_ack(1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 1'b0, 1'b1); wait_ack(1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0, 1'b1); wait_ack(1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0, 1'b1); wait_ack(1'b0);
    issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 1'b0, 1'b1); wait_ack(1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1); wait_ack(1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'h14, 32'hDEADBEEF, 1'b0, 1'b1); wait_ack(1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h18, 32'hCAFEF00D, 1'b1, 1'b1); wait_ack(1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0, 1'b1); wait_ack(1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h1A, 32'h0, 1'b0, 1'b1); wait_ack(1'b0);

    issue(1'b1, 2'd0, 1'b0, 32'h10, 32'h00000055, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b0;
    req  = 1'b0;
    #1;
    check_zero("midreset");
    sb.delete();
    we_seen   = 0;
    ref_rdata = 32'd0;
    @(negedge clk);
    clrn = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1); wait_ack(1'b0);

    h_prev = 1'b0;
    for (int k = 0; k < 200; k++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 255)), $urandom, h_prev, 1'b1);
      h = (k != 199) && ($urandom_range(0, 3) == 0);
      wait_ack(h);
      h_prev = h;
    end

    repeat (6) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mcmem_ctrl.md
# mcmem_ctrl

Memory access sequencer between the multicycle CPU datapath and the word-wide synchronous data memory, which has registered address/data/write-enable and a registered output. Accepts one load or store request at a time over a req/ack handshake and waits out the memory read latency. Performs byte and halfword stores as read-modify-write, because the memory only writes whole words. Returns loads as byte-lane-extracted, sign- or zero-extended 32-bit values.

## Interface
- `MEM_LAT`, default 2: memory read latency in clock edges, counted from the address being presented to data appearing on `m_dataout`. Legal range 1..7.
- `clk` in 1: single clock; the memory shares it.
- `clrn` in 1: asynchronous, active-low reset.
- `req` in 1: request, level. Sampled only in IDLE.
- `wr` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 halfword, 10 word; 11 is illegal.
- `sext` in 1: sign-extend a byte or halfword load.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-justified.
- `ack` out 1: one-cycle completion pulse.
- `rdata` out 32: load result; holds until the next load completes.
- `misalign` out 1: error pulse, coincident with `ack`.
- `m_addr` out 32: memory address; the memory uses bits [7:2].
- `m_datain` out 32: memory write word.
- `m_we` out 1: memory write enable.
- `m_dataout` in 32: memory read word.

## Operation
- Byte order is little-endian: byte k occupies bits [8k+7:8k] and is selected by `addr[1:0]`. A halfword is selected by `addr[1]`.
- On `req` in IDLE, latch `wr`, `size`, `sext`, `addr` and `wdata`, then branch:
  - Misaligned access (halfword with `addr[0]`=1, word with `addr[1:0]`≠0) or `size`=11: go to ERR.
  - Word store: go to WRITE.
  - Any other access (all loads, byte/halfword stores): go to READ.
- READ: lasts MEM_LAT+1 cycles, tracked by a 3-bit counter running 0..MEM_LAT. At the edge ending count MEM_LAT, capture `m_dataout` into the read buffer.
  - Load: go to DONE. `rdata` is updated from the buffer at that edge: the lane is extracted, then extended with sign if `sext`, else zero.
  - Sub-word store: go to WRITE.
- WRITE: `m_we`=1 for exactly this one cycle, then go to DONE.
  - Word store: `m_datain` = `wdata`.
  - Sub-word store: `m_datain` = read buffer with the selected lane replaced by `wdata[7:0]` or `wdata[15:0]`.
- DONE: `ack`=1 for one cycle, then go to IDLE.
- ERR: `ack`=1 and `misalign`=1 for one cycle, then go to IDLE. No memory write occurs.
- `m_addr` = latched address in every state; IDLE retains the last latched value.
- `m_we`=0 in every state except WRITE.
- `req` is ignored outside IDLE. If `req` is still high in the IDLE cycle after DONE, a new transaction starts; the requester drops `req` on `ack`.
- Reset values: state IDLE, counter 0, `ack` 0, `misalign` 0, `m_we` 0, `rdata` 0, `m_addr` 0, `m_datain` 0, read buffer 0.
- Reset mid-operation: `clrn` low forces reset values immediately.
  - A sub-word store interrupted before WRITE leaves memory unchanged.
  - A reset during WRITE drops `m_we` at once; completion of that write is not guaranteed.

## Timing
Cycle 0 is the cycle in which `req` is sampled.
- Load: READ spans cycles 1..MEM_LAT+1; `ack` and valid `rdata` in cycle MEM_LAT+2 (cycle 4 for MEM_LAT=2).
- Word store: `m_we` in cycle 1, `ack` in cycle 2.
- Sub-word store: READ spans cycles 1..MEM_LAT+1, `m_we` in cycle MEM_LAT+2, `ack` in cycle MEM_LAT+3 (cycle 5 for MEM_LAT=2).
- Error: `ack` and `misalign` in cycle 1.
- Minimum spacing between two requests is one IDLE cycle after DONE/ERR.
- All outputs are registered or decoded from registered state; there is no combinational path from `req` to any output.

## Configuration
- `MCMEM_CTRL_ALIGN_TRAP_EN` defined: misaligned accesses and `size`=11 take ERR exactly as described above.
- Not defined:
  - Offending low address bits are ignored: word uses `addr[1:0]`=00, halfword uses `addr[0]`=0.
  - `size`=11 is treated as a word.
  - The access proceeds normally and `misalign` is tied 0.

## Test plan
Bench memory model: registered SRAM with MEM_LAT=2, preloaded with word 0x10 = 0x8899AABB.
- Word load from 0x10 -> `ack` in cycle 4, `rdata`=0x8899AABB, `m_we` never asserted.
- Byte load from 0x13 with `sext`=1 -> `rdata`=0xFFFFFF88. Byte load from 0x11 with `sext`=0 -> `rdata`=0x000000AA.
- Halfword store of 0x00001234 to 0x12 -> `m_we` high only in cycle 4, `ack` in cycle 5. Word load from 0x10 then returns 0x1234AABB.
- Word store of 0xDEADBEEF to 0x14 -> `m_we` in cycle 1, `ack` in cycle 2. Readback gives 0xDEADBEEF. With `req` held high, a second store starts in the IDLE cycle 3.
- Word load from 0x12:
  - With the macro: `ack` and `misalign` in cycle 1, no memory write.
  - Without the macro: `rdata`=0x8899AABB, `misalign`=0.
- `clrn` pulsed low in cycle 2 of a byte store to 0x10 -> all outputs return to 0 immediately, word 0x10 is unchanged, and the next load completes normally.
